spread_tx: RTL

SPREAD_TX -- requirements
Module: spread_tx

---
 rtl/spread_tx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/spread_tx.sv
// spread_tx -- direct-sequence spreader for a serial LVDS chip stream.
//
// Each accepted payload bit is XORed with one full period (L = 2^W-1 chips)
// of a Fibonacci-style PN code; every chip is held for CHIP_DIV clocks.
//
// Ports:
//   clk        : single clock, rising edge
//   rst        : asynchronous reset, active low
//   data_valid : data_bit is offered
//   data_bit   : payload bit to spread
//   data_ready : block accepts data_bit this cycle
//   tx_out     : registered chip stream
//   chip_stb   : pulse on the first cycle of every chip
//   epoch      : pulse on the first cycle of chip 0 of a code period
//   busy       : high while a payload bit is being sent
//
// Build option: define SPREAD_TX_IDLE_CARRIER_EN to free-run the code with
// data 0 while idle, so that payload bits always start on a code epoch.
module spread_tx #(
  parameter int                    CHIP_DIV   = 48,
  parameter int                    LFSR_WIDTH = 10,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = LFSR_WIDTH'(10'h240),
  parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_WIDTH'(1)
) (
  input  logic clk,
  input  logic rst,
  input  logic data_valid,
  input  logic data_bit,
  output logic data_ready,
  output logic tx_out,
  output logic chip_stb,
  output logic epoch,
  output logic busy
);

  localparam int W  = LFSR_WIDTH;
  localparam int L  = (1 << W) - 1;
  localparam int DW = $clog2(CHIP_DIV);

`ifdef SPREAD_TX_IDLE_CARRIER_EN
  localparam bit IDLE_CARRIER = 1'b1;
`else
  localparam bit IDLE_CARRIER = 1'b0;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   lfsr_q, lfsr_d;
  logic [DW-1:0]  div_q, div_d;
  logic [W-1:0]   chip_q, chip_d;
  logic           bit_q, bit_d;
  logic           tx_out_q, tx_out_d;
  logic           chip_stb_q, chip_stb_d;
  logic           epoch_q, epoch_d;
  // Keeps data_ready low on the first cycle after reset release.
  logic           init_q, init_d;

  logic           wrap, last, run, accept;
  logic [W-1:0]   lfsr_step;

  assign wrap      = (div_q == DW'(CHIP_DIV - 1));
  assign last      = wrap && (chip_q == W'(L - 1));
  assign lfsr_step = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
  // Code generator advances while sending, or always with the idle carrier.
  assign run       = (state_q == SEND) || IDLE_CARRIER;
  assign accept    = data_valid && data_ready;
  assign init_d    = 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    data_ready = 1'b0;
    if (init_q) begin
      if (state_q == IDLE) data_ready = IDLE_CARRIER ? last : 1'b1;
      else                 data_ready = last;
    end
  end

  assign busy = (state_q == SEND);

  // Datapath: code generator, counters and the registered chip output
  always_comb begin
    lfsr_d     = lfsr_q;
    div_d      = div_q;
    chip_d     = chip_q;
    bit_d      = bit_q;
    tx_out_d   = tx_out_q;
    chip_stb_d = 1'b0;
    epoch_d    = 1'b0;
    if (accept) begin
      // Restart the code from the seed; first chip shows up next cycle.
      lfsr_d     = SEED;
      div_d      = '0;
      chip_d     = '0;
      bit_d      = data_bit;
      tx_out_d   = SEED[W-1] ^ data_bit;
      chip_stb_d = 1'b1;
      epoch_d    = 1'b1;
    end else if (run) begin
      if (wrap) begin
        lfsr_d = lfsr_step;
        div_d  = '0;
        chip_d = last ? '0 : chip_q + W'(1);
        if (state_d == IDLE) bit_d = 1'b0;
        if (state_d == SEND || IDLE_CARRIER) begin
          tx_out_d   = lfsr_step[W-1] ^ bit_d;
          chip_stb_d = 1'b1;
          epoch_d    = last;
        end else begin
          tx_out_d = 1'b0;
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end else begin
      tx_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q     <= SEED;
      div_q      <= '0;
      chip_q     <= '0;
      bit_q      <= 1'b0;
      tx_out_q   <= 1'b0;
      chip_stb_q <= 1'b0;
      epoch_q    <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      div_q      <= div_d;
      chip_q     <= chip_d;
      bit_q      <= bit_d;
      tx_out_q   <= tx_out_d;
      chip_stb_q <= chip_stb_d;
      epoch_q    <= epoch_d;
      init_q     <= init_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign chip_stb = chip_stb_q;
  assign epoch    = epoch_q;

endmodule
